// File: rtl/pixel_readout_capture_pkg.sv
// Shared sensor definitions: capture FSM states, buffered word layout and
// default frame geometry common to the sequencing controller and capture side.
package sensor_pkg;

  localparam int PIXEL_COUNT = 4;
  localparam int DATA_WIDTH  = 8;

  typedef enum logic [2:0] {
    WAIT_ERASE = 3'd0,
    ERASED     = 3'd1,
    EXPOSED    = 3'd2,
    CONVERTED  = 3'd3,
    READING    = 3'd4
  } capture_state_t;

  // Word layout as stored in the output FIFO (MSB first).
  typedef struct packed {
    logic                  sof;
    logic                  eof;
    logic [DATA_WIDTH-1:0] data;
  } pixel_word_t;

endpackage

// File: rtl/pixel_readout_capture_sync_fifo.sv
// Registered show-ahead FIFO: dout always reflects the head entry.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_push, w_do_pop;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pixel_readout_capture.sv
// Capture side of the sensor sequencer: checks phase/index order and buffers pixels.
// Optional frame checksum output enabled by defining PIXEL_CAPTURE_CHECKSUM_EN.
module pixel_readout_capture
  import sensor_pkg::*;
#(
  parameter int PIXEL_COUNT = sensor_pkg::PIXEL_COUNT,
  parameter int DATA_WIDTH  = sensor_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           erase,
  input  logic                           expose,
  input  logic                           convert,
  input  logic                           read,
  input  logic [$clog2(PIXEL_COUNT)-1:0] pixel_select,
  input  logic [DATA_WIDTH-1:0]          pixel_data,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sof,
  output logic                           out_eof,
  output logic                           frame_done,
  output logic                           seq_error,
  output logic                           overflow
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH+$clog2(PIXEL_COUNT)-1:0] frame_checksum
`endif
);

  localparam int IDXW = $clog2(PIXEL_COUNT);
  localparam int WW   = DATA_WIDTH + 2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PIXEL_COUNT - 1);

  capture_state_t  r_state, w_next;
  logic [IDXW-1:0] r_idx;
  logic            r_seq_error, r_overflow, r_frame_done;
  logic            w_err, w_cap, w_cap_ok, w_enter, w_last, w_multi;
  logic            w_pop, w_drop, w_full, w_empty;
  logic [WW-1:0]   w_din, w_dout;

  assign w_multi  = ($countones({erase, expose, convert, read}) > 1);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_cap_ok = w_cap && (pixel_select == r_idx);

  always_comb begin
    w_next  = r_state;
    w_err   = 1'b0;
    w_cap   = 1'b0;
    w_enter = 1'b0;
    if (w_multi) begin
      w_err  = 1'b1;
      w_next = WAIT_ERASE;
    end else begin
      case (r_state)
        WAIT_ERASE: if (erase) begin
                      w_next  = ERASED;
                      w_enter = 1'b1;
                    end else if (expose || convert || read) w_err = 1'b1;
        ERASED:     if (expose) w_next = EXPOSED;
                    else if (convert || read) w_err = 1'b1;
        EXPOSED:    if (convert) w_next = CONVERTED;
                    else if (erase || read) w_err = 1'b1;
        CONVERTED:  if (read) w_cap = 1'b1;
                    else if (erase || expose) w_err = 1'b1;
        READING:    if (read) w_cap = 1'b1;
                    else w_err = 1'b1;  // read fell before the last pixel
        default:    w_next = WAIT_ERASE;
      endcase
      if (w_err) w_next = WAIT_ERASE;
      if (w_cap) begin
        if (!w_cap_ok) begin
          w_err  = 1'b1;
          w_next = WAIT_ERASE;
        end else begin
          w_next = w_last ? WAIT_ERASE : READING;
        end
      end
    end
  end

  assign w_din  = {(r_idx == '0), w_last, pixel_data};
  assign w_pop  = out_ready && !w_empty;
  // Index still advances on a dropped word so the frame stays aligned.
  assign w_drop = w_cap_ok && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= WAIT_ERASE;
      r_idx        <= '0;
      r_seq_error  <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= w_cap_ok && w_last && !r_seq_error && !r_overflow && !w_drop;
      if (w_enter) begin
        r_idx       <= '0;
        r_seq_error <= 1'b0;
        r_overflow  <= 1'b0;
      end else begin
        if (w_cap_ok) r_idx <= r_idx + 1'b1;
        if (w_err)    r_seq_error <= 1'b1;
        if (w_drop)   r_overflow  <= 1'b1;
      end
    end
  end

`ifdef PIXEL_CAPTURE_CHECKSUM_EN
  logic [DATA_WIDTH+IDXW-1:0] r_acc, r_checksum, w_sum;
  assign w_sum = r_acc + (DATA_WIDTH+IDXW)'(pixel_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_checksum <= '0;
    end else begin
      if (w_enter)       r_acc <= '0;
      else if (w_cap_ok) r_acc <= w_sum;
      if (w_cap_ok && w_last && !r_seq_error && !r_overflow && !w_drop)
        r_checksum <= w_sum;
    end
  end
  assign frame_checksum = r_checksum;
`endif

  sync_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_cap_ok),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid  = !w_empty;
  assign out_sof    = w_dout[WW-1];
  assign out_eof    = w_dout[WW-2];
  assign out_data   = w_dout[DATA_WIDTH-1:0];
  assign frame_done = r_frame_done;
  assign seq_error  = r_seq_error;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Directed bench for pixel_readout_capture; checks frame_checksum when
// PIXEL_CAPTURE_CHECKSUM_EN is defined.
module tb_pixel_readout_capture;

  logic       clk = 1'b0;
  logic       reset, erase, expose, convert, read, out_ready;
  logic [1:0] pixel_select;
  logic [7:0] pixel_data, out_data;
  logic       out_valid, out_sof, out_eof, frame_done, seq_error, overflow;
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
  logic [9:0] frame_checksum;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pixel_readout_capture dut (
    .clk(clk), .reset(reset), .erase(erase), .expose(expose), .convert(convert),
    .read(read), .pixel_select(pixel_select), .pixel_data(pixel_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .frame_done(frame_done),
    .seq_error(seq_error), .overflow(overflow)
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
    , .frame_checksum(frame_checksum)
`endif
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic strobes(input logic e, x, c, r);
    erase = e; expose = x; convert = c; read = r;
  endtask

  task automatic run_phases();
    strobes(1, 0, 0, 0); repeat (5) cyc();
    strobes(0, 1, 0, 0); repeat (255) cyc();
    strobes(0, 0, 1, 0); repeat (255) cyc();
  endtask

  task automatic do_read(input logic [1:0] sel, input logic [7:0] d);
    strobes(0, 0, 0, 1); pixel_select = sel; pixel_data = d;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0; pixel_select = '0; pixel_data = '0;
    strobes(0, 0, 0, 0);
    repeat (3) cyc();
    vectors++;
    if ({out_valid, out_sof, out_eof, out_data} !== 11'h000) begin
      miscompares++; $display("FAIL reset_stream got %h want 000", {out_valid, out_sof, out_eof, out_data});
    end
    vectors++;
    if ({frame_done, seq_error, overflow} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got %b want 000", {frame_done, seq_error, overflow});
    end
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
    vectors++;
    if (frame_checksum !== 10'h000) begin
      miscompares++; $display("FAIL reset_checksum got %h want 000", frame_checksum);
    end
`endif
    reset = 1'b0;
    cyc();
  endtask

  // Nominal frame with out_ready=1: each word is visible right after its push edge.
  task automatic test_nominal();
    logic [7:0]  d [4];
    logic [10:0] exp_s;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    out_ready = 1'b1;
    run_phases();
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), d[i]);
      exp_s = {1'b1, (i == 0), (i == 3), d[i]};
      vectors++;
      if ({out_valid, out_sof, out_eof, out_data} !== exp_s) begin
        miscompares++; $display("FAIL nominal_word%0d got %h want %h", i, {out_valid, out_sof, out_eof, out_data}, exp_s);
      end
      vectors++;
      if (frame_done !== (i == 3)) begin
        miscompares++; $display("FAIL nominal_done%0d got %b want %b", i, frame_done, (i == 3));
      end
    end
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
    vectors++;
    if (frame_checksum !== 10'h0AA) begin
      miscompares++; $display("FAIL nominal_checksum got %h want 0aa", frame_checksum);
    end
`endif
    strobes(0, 0, 0, 0);
    cyc();
    vectors++;
    if ({out_valid, frame_done, seq_error, overflow} !== 4'b0000) begin
      miscompares++; $display("FAIL nominal_after got %b want 0000", {out_valid, frame_done, seq_error, overflow});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    run_phases();
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), 8'h11 * (i + 1));
      vectors++;
      if ({out_valid, out_sof, out_eof, out_data} !== 11'h611) begin
        miscompares++; $display("FAIL bp_hold%0d got %h want 611", i, {out_valid, out_sof, out_eof, out_data});
      end
    end
    vectors++;
    if ({frame_done, overflow} !== 2'b10) begin
      miscompares++; $display("FAIL bp_frame1 done/ovf got %b want 10", {frame_done, overflow});
    end
    strobes(0, 0, 0, 0); cyc();
    run_phases();
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), 8'h55 + 8'(i));
      vectors++;
      if (overflow !== 1'b1) begin
        miscompares++; $display("FAIL bp_overflow%0d got %b want 1", i, overflow);
      end
      vectors++;
      if (frame_done !== 1'b0) begin
        miscompares++; $display("FAIL bp_done%0d got %b want 0", i, frame_done);
      end
    end
    strobes(0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({out_valid, out_sof, out_eof, out_data} !== {1'b1, (i == 0), (i == 3), 8'(8'h11 * (i + 1))}) begin
        miscompares++; $display("FAIL bp_drain%0d got %h want %h", i, {out_valid, out_sof, out_eof, out_data},
                                {1'b1, (i == 0), (i == 3), 8'(8'h11 * (i + 1))});
      end
      cyc();
    end
    vectors++;
    if ({out_valid, seq_error} !== 2'b00) begin
      miscompares++; $display("FAIL bp_empty got %b want 00", {out_valid, seq_error});
    end
  endtask

  task automatic test_index_error();
    out_ready = 1'b1;
    run_phases();
    do_read(2'd0, 8'h11);
    vectors++;
    if ({out_valid, out_sof, out_data, seq_error} !== 11'b1_1_00010001_0) begin
      miscompares++; $display("FAIL idx_first got %b want 11000100010", {out_valid, out_sof, out_data, seq_error});
    end
    do_read(2'd2, 8'h33);
    vectors++;
    if ({out_valid, seq_error, frame_done} !== 3'b010) begin
      miscompares++; $display("FAIL idx_err got %b want 010", {out_valid, seq_error, frame_done});
    end
    strobes(0, 0, 0, 0); cyc();
    strobes(1, 0, 0, 0); cyc();
    vectors++;
    if (seq_error !== 1'b0) begin
      miscompares++; $display("FAIL idx_clear got %b want 0", seq_error);
    end
    strobes(0, 0, 0, 0); cyc();
  endtask

  task automatic test_phase_error();
    out_ready = 1'b0;
    strobes(1, 0, 0, 0); repeat (2) cyc();
    strobes(0, 0, 1, 0); cyc();
    vectors++;
    if (seq_error !== 1'b1) begin
      miscompares++; $display("FAIL phase_err got %b want 1", seq_error);
    end
    do_read(2'd0, 8'h5A);
    do_read(2'd1, 8'h5B);
    vectors++;
    if ({out_valid, seq_error} !== 2'b01) begin
      miscompares++; $display("FAIL phase_nocap got %b want 01", {out_valid, seq_error});
    end
    strobes(0, 0, 0, 0); cyc();
  endtask

  task automatic test_reset_mid_read();
    out_ready = 1'b0;
    run_phases();
    do_read(2'd0, 8'h77);
    do_read(2'd1, 8'h88);
    vectors++;
    if ({out_valid, out_data} !== 9'h177) begin
      miscompares++; $display("FAIL rst_pre got %h want 177", {out_valid, out_data});
    end
    #2;
    strobes(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, frame_done, seq_error, overflow} !== 4'b0000) begin
      miscompares++; $display("FAIL rst_async got %b want 0000", {out_valid, frame_done, seq_error, overflow});
    end
    cyc();
    reset = 1'b0;
    cyc();
    vectors++;
    if ({out_valid, frame_done, seq_error} !== 3'b000) begin
      miscompares++; $display("FAIL rst_after got %b want 000", {out_valid, frame_done, seq_error});
    end
    test_nominal();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_index_error();
    test_phase_error();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_readout_capture.md
Name: pixel_readout_capture

Overview:
- Receive-side counterpart of the sensor sequencing controller.
- Monitors the controller's erase/expose/convert/read phase strobes and pixel_select, and samples the pixel array's digitised output on each read cycle.
- Checks phase ordering and pixel index order, and buffers captured pixels in a small FIFO.
- Presents pixels on a valid/ready stream with start-of-frame and end-of-frame markers, for the downstream serializer/host interface.

Parameters:
- PIXEL_COUNT, 4, pixels per frame; must match the controller.
- DATA_WIDTH, 8, bits per pixel sample.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- erase  input  1  controller erase phase strobe (level)
- expose  input  1  controller expose phase strobe (level)
- convert  input  1  controller convert phase strobe (level)
- read  input  1  controller read phase strobe; one pixel per high cycle
- pixel_select  input  $clog2(PIXEL_COUNT)  index of the pixel being read
- pixel_data  input  DATA_WIDTH  ADC output for the selected pixel; valid in the same cycle as read
- out_data  output  DATA_WIDTH  buffered pixel
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts the word
- out_sof  output  1  word is pixel 0 of the frame
- out_eof  output  1  word is pixel PIXEL_COUNT-1 of the frame
- frame_done  output  1  one-cycle pulse after a complete, error-free frame is captured
- seq_error  output  1  sticky phase-order or index-order violation
- overflow  output  1  sticky: a pixel was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous) values:
  - FSM in WAIT_ERASE.
  - FIFO empty, all outputs 0, expected index 0.
- States and transitions, evaluated on each clk edge:
  - WAIT_ERASE -> ERASED when erase=1.
  - ERASED -> EXPOSED when expose=1.
  - EXPOSED -> CONVERTED when convert=1.
  - CONVERTED -> READING when read=1. That same cycle is also a capture cycle.
  - READING -> WAIT_ERASE after the capture of index PIXEL_COUNT-1, or when read falls early.
- Phase checks:
  - More than one strobe high at once, or a strobe arriving out of order (e.g. read in ERASED), sets seq_error and forces WAIT_ERASE.
  - All strobes low between phases is legal; the FSM holds.
- Capture, on every cycle with read=1 in CONVERTED or READING:
  - If pixel_select equals the expected index, push {sof = (idx==0), eof = (idx==PIXEL_COUNT-1), pixel_data} into the FIFO, then increment the expected index.
  - If pixel_select does not match, set seq_error, push nothing, and discard the rest of the frame (FSM -> WAIT_ERASE).
- Early end of frame: read falling before index PIXEL_COUNT-1 sets seq_error. Words already pushed remain in the FIFO, and no eof word is generated.
- frame_done pulses 1 cycle after the eof push, only if seq_error and overflow did not rise during that frame.
- Sticky flag clearing: seq_error and overflow clear on entry to ERASED (start of a new frame) or on reset. They are not cleared otherwise.
- FIFO:
  - Registered show-ahead. out_valid = not empty; out_data, out_sof and out_eof come from the head entry.
  - Pop when out_valid and out_ready are both 1.
  - A push into an empty FIFO is visible on out_valid on the next cycle (1-cycle latency).
- FIFO boundary conditions:
  - Push while full with no simultaneous pop: word dropped, overflow set, expected index still advances.
  - Simultaneous push and pop while full: legal, no overflow.
  - Simultaneous push and pop while empty: the push is stored; the pop is ignored because out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. An occupancy counter of width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- Reset mid-frame: FIFO flushed, FSM to WAIT_ERASE, frame abandoned with no frame_done.
- Downstream stream stability: while out_valid=1 and out_ready=0, out_data, out_sof and out_eof hold stable.

Optional Feature:
- Macro: PIXEL_CAPTURE_CHECKSUM_EN
- When defined:
  - Adds output port frame_checksum, width DATA_WIDTH+$clog2(PIXEL_COUNT).
  - It is the unsigned sum of all pixel_data values accepted in the frame (including any words dropped on overflow).
  - It updates in the same cycle frame_done pulses and holds until the next frame_done or reset; reset value 0.
  - The accumulator clears on entry to ERASED.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package sensor_pkg holds:
  - enum capture_state_t: WAIT_ERASE, ERASED, EXPOSED, CONVERTED, READING.
  - Packed struct pixel_word_t {sof, eof, data}.
  - Default constants PIXEL_COUNT and DATA_WIDTH, shared with the controller.
- Sub-module sync_fifo: parameterised width and depth; ports push, pop, din, dout, full, empty.
- Control FSM, index checker and checksum remain in pixel_readout_capture.

Test Plan:
- Nominal frame: erase 5 cycles, expose 255, convert 255, then read 4 cycles with pixel_select 0,1,2,3 and pixel_data 0x11,0x22,0x33,0x44; out_ready=1 -> out stream 0x11(sof), 0x22, 0x33, 0x44(eof); frame_done pulses once; no flags set.
- Backpressure: same frame with out_ready=0 and FIFO_DEPTH=4 -> 4 words held stable, overflow=0. Then a second frame with out_ready still 0 -> overflow=1 on the first push, frame_done not pulsed. Releasing out_ready drains 0x11..0x44 in order.
- Index error: read sequence 0,2 -> seq_error=1 at the pixel_select=2 cycle, only 0x11 pushed, FSM to WAIT_ERASE; the next erase clears seq_error.
- Phase error: erase then convert without expose -> seq_error=1, nothing captured when read follows.
- Reset mid-read: assert reset after 2 pixels pushed -> out_valid=0 immediately, all flags 0; the following clean frame captures normally.
- With PIXEL_CAPTURE_CHECKSUM_EN defined: the nominal frame gives frame_checksum=0xAA, coincident with frame_done.
